fifo_rx: RTL and testbench
==========================

# fifo_rx

Receive-side byte buffer for the Zigbee baseband. Accepts the demodulated serial bit stream one bit per `bit_valid` strobe, LSB first, and assembles 8-bit bytes. Complete bytes go into a DEPTH-entry FIFO that the processor drains over an APB slave port. It is the counterpart of the transmit FIFO, which serializes APB-written bytes LSB first at 2 MHz.

## Interface
- `WIDTH`, 8: byte width; only 8 is supported.
- `DEPTH`, 64: FIFO entries; must be a power of two. `PTR_WIDTH = $clog2(DEPTH)`.
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `en_rx`  in  1  frame-active qualifier from the demodulator; low discards any partial byte.
- `data_in`  in  1  demodulated bit; sampled only when `bit_valid` = 1.
- `bit_valid`  in  1  one-`clk` strobe per received bit, nominally every 25 clocks (2 MHz); arbitrary spacing ≥1 clock must work.
- `psel`, `penable`, `pwrite`  in  1 each  APB control.
- `pwdata`  in  8  APB write data (control command).
- `prdata`  out  8  APB read data.
- `pready`  out  1  tied to 1 (zero wait states).
- `pslverr`  out  1  error on the current access.
- `mem_state`  out  1  0 = FIFO empty; 1 = one or more bytes stored.
- `overflow`  out  1  sticky; a completed byte was dropped because the FIFO was full.
- `level`  out  PTR_WIDTH+1  number of stored bytes, 0..DEPTH.

## Operation
- **Reset values.** `prdata` = 0, `pready` = 1, `pslverr` = 0, `mem_state` = 0, `overflow` = 0, `level` = 0. Pointers and bit counter are cleared. Memory contents need not be reset.
- **Assembler FSM.** Two states, IDLE and SHIFT.
  - IDLE → SHIFT when `en_rx` = 1.
  - SHIFT → IDLE when `en_rx` = 0. The bit counter and shift register are cleared; any partial byte is discarded and not counted as overflow.
  - In IDLE, `bit_valid` is ignored.
  - In SHIFT, on `bit_valid` the bit is placed at `byte[bit_cnt]` and the 3-bit `bit_cnt` increments, wrapping 7→0. The first received bit is bit 0.
  - `bit_valid` is honoured on the same cycle `en_rx` rises.
- **Byte completion.** This is the `bit_valid` with `bit_cnt` = 7. The assembled byte, including the current bit, is pushed.
  - The push is accepted if the FIFO is not full, or if it is full and a valid APB read pops in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set.
- **FIFO.** Read and write pointers are PTR_WIDTH+1 bits.
  - Empty: pointers are fully equal. Full: low bits equal and MSBs differ.
  - Pointers wrap modulo 2·DEPTH.
  - `level` = `wr_ptr` − `rd_ptr` (PTR_WIDTH+1 bit subtraction).
  - `mem_state` = !empty.
- **APB read.** An access phase with `psel` & `penable` & !`pwrite`.
  - Not empty: `prdata` = mem[`rd_ptr`] (combinational), `pslverr` = 0, and `rd_ptr` increments at the clock edge.
  - Empty: `prdata` = 0, `pslverr` = 1, no pop.
  - Outside a read access, `prdata` = 0.
- **APB write.** An access phase with `pwrite` = 1 is a command; `pslverr` = 0.
  - `pwdata[0]` = 1 clears `overflow`.
  - `pwdata[1]` = 1 flushes the FIFO: `rd_ptr` ← `wr_ptr`.
  - Both bits may be set together. Other bits are ignored.
- **Simultaneous events.**
  - Flush and byte completion in the same cycle: flush wins, the byte is discarded, and `overflow` is not set.
  - Overflow-clear and a new drop in the same cycle: `overflow` ends at 1 (set wins).
  - Push and pop in the same cycle while not empty: both occur and `level` is unchanged.
  - Push and pop when empty: pop errors, push is accepted, `level` = 1.
- **Reset mid-operation.** Synchronous reset returns all state to reset values at the next edge, including mid-byte and while full.

## Timing
- Byte-completion `bit_valid` at edge N → `level`/`mem_state` updated and the byte readable from edge N+1.
- APB read is zero wait: data and `pslverr` are valid in the access cycle; `level` decrements after that edge.
- `overflow` asserts the cycle after the dropped byte's completion edge and clears the cycle after the clear command.
- All outputs except `prdata`/`pslverr` are registered or derived from registers only. `prdata`/`pslverr` additionally depend combinationally on the APB inputs.

## Test plan
1. **Reset.** Assert `reset` 2 clocks → all outputs at reset values. An APB read returns `pslverr` = 1, `prdata` = 0.
2. **Single byte.** `en_rx` = 1; bits 1,0,1,0,0,1,0,1 with `bit_valid` every 25 clocks → `level` = 1 and `mem_state` = 1 one clock after the 8th strobe. The read returns 0xA5 with `pslverr` = 0; afterwards `mem_state` = 0.
3. **Fill and overflow.** Receive bytes 0x00..0x3F, then 0xFF → `level` = 64 and `overflow` = 1. 64 reads return 0x00..0x3F in order; the 65th read gives `pslverr` = 1.
4. **Partial byte discard.** Send 3 bits, drop `en_rx` for 1 clock, then send 0x3C → only 0x3C is stored, `level` = 1, `overflow` = 0.
5. **Full with pop.** With the FIFO full, the 8th bit of 0x77 coincides with an APB read → the read returns the oldest byte, 0x77 is accepted, `level` stays 64, `overflow` = 0.
6. **Flush, clear, reset.** Store 10 bytes with `overflow` set; write 0x03 → `level` = 0, `mem_state` = 0, `overflow` = 0. Assert `reset` after 4 bits of the next byte, then send 0x5A → 0x5A is read back.

Source files
------------

// File: rtl/fifo_rx_if.sv
// APB slave bundle for the receive FIFO: control, write data and the read/response path.
interface fifo_rx_if #(parameter int WIDTH = 8);
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [WIDTH-1:0] pwdata;
  logic [WIDTH-1:0] prdata;
  logic             pready;
  logic             pslverr;

  modport master (output psel, penable, pwrite, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/fifo_rx.sv
// Zigbee receive path: LSB-first bit assembler feeding a DEPTH-entry byte FIFO drained over APB.
module fifo_rx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_rx,
  input  logic               data_in,
  input  logic               bit_valid,
  fifo_rx_if.slave           apb,
  output logic               mem_state,
  output logic               overflow,
  output logic [PTR_WIDTH:0] level
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]           state, state_nxt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [WIDTH-1:0]     shreg, byte_done;
  logic [PTR_WIDTH:0]   wr_ptr, rd_ptr;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic take, complete, empty, full;
  logic rd_acc, wr_acc, pop, flush, push, drop;
  logic unused_pwdata;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_rx)  state_nxt = SHIFT;
      SHIFT:   if (!en_rx) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Looking at the next state lets a strobe count on the same cycle en_rx rises.
  assign take     = bit_valid && (state_nxt == SHIFT);
  assign complete = take && (bit_cnt == CNT_W'(WIDTH-1));

  always_comb begin
    byte_done            = shreg;
    byte_done[WIDTH-1]   = data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == IDLE) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (take) begin
        shreg[bit_cnt] <= data_in;
        bit_cnt        <= bit_cnt + 1'b1;
      end
    end
  end

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                  (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);
  assign rd_acc = apb.psel && apb.penable && !apb.pwrite;
  assign wr_acc = apb.psel && apb.penable && apb.pwrite;
  assign pop    = rd_acc && !empty;
  assign flush  = wr_acc && apb.pwdata[1];
  // A pop in the same cycle frees the slot a full FIFO needs; flush discards the byte outright.
  assign push   = complete && !flush && (!full || pop);
  assign drop   = complete && !flush && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop)                           overflow <= 1'b1;
      else if (wr_acc && apb.pwdata[0])   overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_WIDTH-1:0]] <= byte_done;
  end

  assign apb.prdata  = pop ? mem[rd_ptr[PTR_WIDTH-1:0]] : '0;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = rd_acc && empty;
  assign mem_state   = !empty;
  assign level       = wr_ptr - rd_ptr;

  assign unused_pwdata = &{1'b0, apb.pwdata[WIDTH-1:2]};
endmodule

// File: tb/tb_fifo_rx.sv
// Scoreboard bench for fifo_rx: bytes queued on send, compared on APB read.
module tb_fifo_rx;
  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en_rx = 1'b0;
  logic       data_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       mem_state, overflow;
  logic [6:0] level;

  fifo_rx_if #(.WIDTH(8)) apb();

  fifo_rx #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en_rx(en_rx), .data_in(data_in),
    .bit_valid(bit_valid), .apb(apb.slave), .mem_state(mem_state),
    .overflow(overflow), .level(level)
  );

  always #10 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb[$];
  logic       exp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(sb.size()));
    chk({tag, ".mem_state"}, 32'(mem_state), 32'(sb.size() != 0));
    chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic send_bit(input logic b, input int gap);
    bit_valid = 1'b1;
    data_in   = b;
    tick();
    bit_valid = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < 8; i++) send_bit(b[i], gap);
    if (sb.size() < DEPTH) sb.push_back(b);
    else                   exp_ovf = 1'b1;
  endtask

  task automatic apb_read(input string tag);
    apb.psel   = 1'b1;
    apb.pwrite = 1'b0;
    tick();
    apb.penable = 1'b1;
    #1;
    if (sb.size() > 0) begin
      chk({tag, ".pslverr"}, 32'(apb.pslverr), 32'd0);
      chk({tag, ".prdata"}, 32'(apb.prdata), 32'(sb.pop_front()));
    end else begin
      chk({tag, ".pslverr"}, 32'(apb.pslverr), 32'd1);
      chk({tag, ".prdata"}, 32'(apb.prdata), 32'd0);
    end
    tick();
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
  endtask

  task automatic apb_write(input logic [7:0] v);
    apb.psel   = 1'b1;
    apb.pwrite = 1'b1;
    apb.pwdata = v;
    tick();
    apb.penable = 1'b1;
    #1;
    chk("wr.pslverr", 32'(apb.pslverr), 32'd0);
    tick();
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
  endtask

  // Last bit of b lands in the same cycle as an APB read access phase.
  task automatic byte_with_read(input logic [7:0] b, input string tag);
    for (int i = 0; i < 7; i++) send_bit(b[i], 1);
    apb.psel   = 1'b1;
    apb.pwrite = 1'b0;
    tick();
    apb.penable = 1'b1;
    bit_valid   = 1'b1;
    data_in     = b[7];
    #1;
    if (sb.size() > 0) begin
      chk({tag, ".pslverr"}, 32'(apb.pslverr), 32'd0);
      chk({tag, ".prdata"}, 32'(apb.prdata), 32'(sb.pop_front()));
    end else begin
      chk({tag, ".pslverr"}, 32'(apb.pslverr), 32'd1);
      chk({tag, ".prdata"}, 32'(apb.prdata), 32'd0);
    end
    tick();
    bit_valid   = 1'b0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    sb.push_back(b);
  endtask

  initial begin
    logic [7:0] b;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.pwdata = '0;

    // Reset values, then a read of the empty FIFO
    reset = 1'b1;
    tick(); tick();
    chk("rst.prdata", 32'(apb.prdata), 32'd0);
    chk("rst.pready", 32'(apb.pready), 32'd1);
    chk("rst.pslverr", 32'(apb.pslverr), 32'd0);
    chk_state("rst");
    reset = 1'b0;
    tick();
    apb_read("rst_rd");

    // Single byte at the nominal bit rate
    en_rx = 1'b1;
    b = 8'hA5;
    for (int i = 0; i < 7; i++) send_bit(b[i], 25);
    chk("a5.level_pre", 32'(level), 32'd0);
    send_bit(b[7], 1);
    sb.push_back(b);
    chk_state("a5_post");
    apb_read("a5_rd");
    chk_state("a5_drained");

    // Fill, overflow, drain past empty
    for (int k = 0; k < DEPTH; k++) send_byte(8'(k), 3);
    send_byte(8'hFF, 3);
    chk_state("fill");
    chk("fill.level64", 32'(level), 32'd64);
    for (int k = 0; k < DEPTH + 1; k++) apb_read("fill_rd");
    chk_state("fill_drained");
    apb_write(8'h01);
    exp_ovf = 1'b0;
    chk_state("ovf_clr");

    // Partial byte dropped by en_rx low
    send_bit(1'b1, 2); send_bit(1'b0, 2); send_bit(1'b1, 2);
    en_rx = 1'b0;
    tick();
    en_rx = 1'b1;
    send_byte(8'h3C, 2);
    chk_state("partial");
    apb_read("partial_rd");

    // Push and pop together on an empty FIFO
    byte_with_read(8'h11, "empty_pp");
    chk_state("empty_pp");
    apb_read("empty_pp_rd");

    // Full FIFO with a pop coinciding with the completing bit
    for (int k = 0; k < DEPTH; k++) send_byte(8'(k + 8'h40), 1);
    chk_state("full2");
    byte_with_read(8'h77, "full_pp");
    chk_state("full_pp");

    // Overflow with 10 stored, then flush + clear, then reset mid-byte
    send_byte(8'hEE, 1);
    for (int k = 0; k < DEPTH - 10; k++) apb_read("ten_rd");
    chk_state("ten");
    apb_write(8'h03);
    sb.delete();
    exp_ovf = 1'b0;
    chk_state("flush");
    b = 8'hC3;
    for (int i = 0; i < 4; i++) send_bit(b[i], 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_state("midrst");
    send_byte(8'h5A, 25);
    chk_state("post_rst");
    apb_read("post_rst_rd");
    chk_state("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
